ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- Sits beside the PS/2 keyboard receiver on the same PS2_CLOCK/PS2_DATA pair.
- Drives both lines open-drain through output-enables: oe=1 pulls the line low, oe=0 releases it.
- Asserts busy so the receiver path can discard traffic during a transmit.

---
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, then shifts one command byte
// out on device clock falls and checks the device acknowledge. Both lines are open-drain.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       PS2_CLOCK,
    input  logic       PS2_DATA,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int MAX_CYCLES = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_SEND    = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         bitIdx_q, bitIdx_d;
    logic [9:0]         frame_q, frame_d;
    logic               clkOe_q, clkOe_d;
    logic               dataOe_q, dataOe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ackErr_q, ackErr_d;
    logic               timeoutErr_q, timeoutErr_d;

    logic clkMeta_q, clkSync_q, clkPrev_q;
    logic dataMeta_q, dataSync_q;
    logic fall;

    assign fall = clkPrev_q & ~clkSync_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bitIdx_d     = bitIdx_q;
        frame_d      = frame_q;
        clkOe_d      = clkOe_q;
        dataOe_d     = dataOe_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ackErr_d     = ackErr_q;
        timeoutErr_d = timeoutErr_q;

        case (state_q)
            S_IDLE: begin
                clkOe_d  = 1'b0;
                dataOe_d = 1'b0;
                busy_d   = 1'b0;
                // busy_q is still high in the done cycle, so a start there is dropped
                if (tx_start && !busy_q) begin
                    frame_d      = {1'b1, ~^tx_data, tx_data};
                    ackErr_d     = 1'b0;
                    timeoutErr_d = 1'b0;
                    busy_d       = 1'b1;
                    clkOe_d      = 1'b1;
                    timer_d      = '0;
                    state_d      = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    dataOe_d = 1'b1;
                    clkOe_d  = 1'b0;
                    bitIdx_d = 4'd0;
                    timer_d  = '0;
                    state_d  = S_SEND;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_SEND: begin
                if (fall) begin
                    dataOe_d = ~frame_q[bitIdx_q];
                    bitIdx_d = bitIdx_q + 4'd1;
                    timer_d  = '0;
                    if (bitIdx_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    clkOe_d      = 1'b0;
                    dataOe_d     = 1'b0;
                    timeoutErr_d = 1'b1;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (dataSync_q) begin
                        ackErr_d = 1'b1;
                    end
                    timer_d = '0;
                    state_d = S_RELEASE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    clkOe_d      = 1'b0;
                    dataOe_d     = 1'b0;
                    timeoutErr_d = 1'b1;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (clkSync_q && dataSync_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    clkOe_d      = 1'b0;
                    dataOe_d     = 1'b0;
                    timeoutErr_d = 1'b1;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    timer_d = fall ? '0 : timer_q + 1'b1;
                end
            end
            default: begin
                clkOe_d  = 1'b0;
                dataOe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bitIdx_q     <= 4'd0;
            frame_q      <= 10'd0;
            clkOe_q      <= 1'b0;
            dataOe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ackErr_q     <= 1'b0;
            timeoutErr_q <= 1'b0;
            clkMeta_q    <= 1'b0;
            clkSync_q    <= 1'b0;
            clkPrev_q    <= 1'b0;
            dataMeta_q   <= 1'b0;
            dataSync_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bitIdx_q     <= bitIdx_d;
            frame_q      <= frame_d;
            clkOe_q      <= clkOe_d;
            dataOe_q     <= dataOe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ackErr_q     <= ackErr_d;
            timeoutErr_q <= timeoutErr_d;
            clkMeta_q    <= PS2_CLOCK;
            clkSync_q    <= clkMeta_q;
            clkPrev_q    <= clkSync_q;
            dataMeta_q   <= PS2_DATA;
            dataSync_q   <= dataMeta_q;
        end
    end

    assign ps2_clk_oe  = clkOe_q;
    assign ps2_data_oe = dataOe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ackErr_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT,
// expected data-line drive and completion status are queued at start and checked as they appear.
module tb_ps2_host_tx;

    localparam int INHIBIT = 20;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       txStart = 1'b0;
    logic       devClk = 1'b1;
    logic       devData = 1'b1;
    logic       ps2Clock, ps2Data;
    logic       ps2ClkOe, ps2DataOe, busy, done, ackErr, timeoutErr;

    int testsRun = 0;
    int testsFailed = 0;

    bit expOeQ[$];
    bit expAckQ[$];
    bit expToQ[$];

    // Open-drain wired-AND of host and device on each line
    assign ps2Clock = devClk & ~ps2ClkOe;
    assign ps2Data  = devData & ~ps2DataOe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (txData),
        .tx_start   (txStart),
        .PS2_CLOCK  (ps2Clock),
        .PS2_DATA   (ps2Data),
        .ps2_clk_oe (ps2ClkOe),
        .ps2_data_oe(ps2DataOe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ackErr),
        .timeout_err(timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit oddParity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) ones++;
        end
        return (ones % 2 == 0);
    endfunction

    task automatic checkResult(input string name);
        bit expAck, expTo;
        expAck = expAckQ.pop_front();
        expTo  = expToQ.pop_front();
        checkOutput($sformatf("%s_ackErr", name), 32'(ackErr), 32'(expAck));
        checkOutput($sformatf("%s_timeoutErr", name), 32'(timeoutErr), 32'(expTo));
        checkOutput($sformatf("%s_clkOeDone", name), 32'(ps2ClkOe), 32'd0);
        checkOutput($sformatf("%s_dataOeDone", name), 32'(ps2DataOe), 32'd0);
        checkOutput($sformatf("%s_busyAtDone", name), 32'(busy), 32'd1);
        tick(1);
        checkOutput($sformatf("%s_donePulse", name), 32'(done), 32'd0);
        checkOutput($sformatf("%s_busyAfter", name), 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit alive, input bit giveAck,
                                 input int resetAfter, input bit midStart, input string name);
        int cnt;
        int k;
        for (int i = 0; i < 8; i++) expOeQ.push_back(!b[i]);
        expOeQ.push_back(!oddParity(b));
        expOeQ.push_back(1'b0);
        expAckQ.push_back(alive && !giveAck);
        expToQ.push_back(!alive);

        txData  = b;
        txStart = 1'b1;
        tick(1);
        txStart = 1'b0;
        checkOutput($sformatf("%s_busyStart", name), 32'(busy), 32'd1);
        checkOutput($sformatf("%s_clkOeStart", name), 32'(ps2ClkOe), 32'd1);

        cnt = 1;
        for (int c = 0; c < 100 && ps2ClkOe; c++) begin
            tick(1);
            if (ps2ClkOe) cnt++;
        end
        checkOutput($sformatf("%s_inhibitLen", name), 32'(cnt), 32'(INHIBIT));
        checkOutput($sformatf("%s_startBit", name), 32'(ps2DataOe), 32'd1);

        if (!alive) begin
            k = 0;
            while (!done && k < 300) begin
                tick(1);
                k++;
            end
            checkOutput($sformatf("%s_timeoutAt", name), 32'(k), 32'(TIMEOUT));
            repeat (10) void'(expOeQ.pop_front());
            checkResult(name);
            return;
        end

        for (int p = 0; p < 11; p++) begin
            if (p == 10 && giveAck) devData = 1'b0;
            tick(HALF);
            devClk = 1'b0;
            tick(HALF);
            if (p < 10) begin
                checkOutput($sformatf("%s_fall%0d", name, p + 1), 32'(ps2DataOe), 32'(expOeQ.pop_front()));
            end
            if (midStart && p == 3) begin
                txData  = ~b;
                txStart = 1'b1;
                tick(1);
                txStart = 1'b0;
            end
            devClk = 1'b1;
            if (p == 10) devData = 1'b1;
            if (resetAfter == p + 1) begin
                rst = 1'b0;
                tick(1);
                checkOutput($sformatf("%s_rstClkOe", name), 32'(ps2ClkOe), 32'd0);
                checkOutput($sformatf("%s_rstDataOe", name), 32'(ps2DataOe), 32'd0);
                checkOutput($sformatf("%s_rstBusy", name), 32'(busy), 32'd0);
                checkOutput($sformatf("%s_rstDone", name), 32'(done), 32'd0);
                checkOutput($sformatf("%s_rstErrs", name), 32'({ackErr, timeoutErr}), 32'd0);
                rst = 1'b1;
                expOeQ.delete();
                expAckQ.delete();
                expToQ.delete();
                tick(3);
                return;
            end
        end

        k = 0;
        while (!done && k < 50) begin
            tick(1);
            k++;
        end
        checkOutput($sformatf("%s_doneSeen", name), 32'(done), 32'd1);
        checkResult(name);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        tick(3);
        checkOutput("reset_clkOe", 32'(ps2ClkOe), 32'd0);
        checkOutput("reset_dataOe", 32'(ps2DataOe), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_errs", 32'({ackErr, timeoutErr}), 32'd0);
        rst = 1'b1;
        tick(3);

        applyStimulus(8'hED, 1'b1, 1'b1, 0, 1'b0, "ed_ack");
        tick(5);
        applyStimulus(8'h07, 1'b1, 1'b1, 0, 1'b0, "x07_ack");
        tick(5);
        applyStimulus(8'hFF, 1'b1, 1'b0, 0, 1'b0, "ff_noack");
        tick(5);
        applyStimulus(8'hA5, 1'b0, 1'b0, 0, 1'b0, "dead");
        tick(5);
        applyStimulus(8'hED, 1'b1, 1'b1, 0, 1'b1, "busy_start");
        tick(5);
        applyStimulus(8'h3C, 1'b1, 1'b1, 5, 1'b0, "mid_reset");
        tick(5);
        applyStimulus(8'h55, 1'b1, 1'b1, 0, 1'b0, "x55_after_rst");
        tick(5);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
